// File: rtl/tmul_pkg.sv
// Shared width constants and carry-save helpers for the TMUL multiplier core.
package tmul_pkg;
  localparam int OPND_W    = 32;
  localparam int PROD_W    = 64;
  localparam int BOOTH_GRP = 3;
  localparam int NUM_PP    = 11;

  function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                                input logic [PROD_W-1:0] y,
                                                input logic [PROD_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  // Carry row is pre-shifted; the carry out of bit 63 is dropped (mod 2^64).
  function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction
endpackage

// File: rtl/booth_radix_8.sv
// Radix-8 Booth recoder: 11 overlapping 4-bit groups of the zero-extended
// multiplier, each mapped to a one-hot magnitude plus a sign bit.
module booth_radix_8
  import tmul_pkg::*;
(
  input  logic [OPND_W-1:0] b,
  output logic [NUM_PP-1:0] one,
  output logic [NUM_PP-1:0] two,
  output logic [NUM_PP-1:0] three,
  output logic [NUM_PP-1:0] four,
  output logic [NUM_PP-1:0] neg
);
  logic [OPND_W+1:0] w_bx;
  logic [3:0]        w_s;

  // w_bx[0] is b[-1] and w_bx[33] is b[32], both zero.
  assign w_bx = {1'b0, b, 1'b0};

  always_comb begin
    one   = '0;
    two   = '0;
    three = '0;
    four  = '0;
    neg   = '0;
    w_s   = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      w_s = w_bx[BOOTH_GRP*i +: 4];
      case (w_s)
        4'b0001, 4'b0010, 4'b1101, 4'b1110: one[i]   = 1'b1;
        4'b0011, 4'b0100, 4'b1011, 4'b1100: two[i]   = 1'b1;
        4'b0101, 4'b0110, 4'b1001, 4'b1010: three[i] = 1'b1;
        4'b0111, 4'b1000:                   four[i]  = 1'b1;
        default: ;
      endcase
      // 4'b1111 is digit zero; keep it positive so no -0 reaches the tree.
      neg[i] = w_s[3] & ~(&w_s[2:0]);
    end
  end
endmodule

// File: rtl/wallace_tree_multiplier_32.sv
// Unsigned 32x32->64 multiplier: radix-8 Booth partial products, Wallace
// carry-save reduction 11->8->6->4->3->2, final adder, one output register.
module wallace_tree_multiplier_32
  import tmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] out
);
  logic [NUM_PP-1:0]        w_one, w_two, w_three, w_four, w_neg;
  logic [OPND_W+1:0]        w_a1, w_a2, w_a3, w_a4;
  logic [OPND_W+1:0]        w_mag;
  logic [PROD_W-1:0]        w_ext;
  logic [NUM_PP*PROD_W-1:0] pp;
  logic [PROD_W-1:0]        w_l1 [8];
  logic [PROD_W-1:0]        w_l2 [6];
  logic [PROD_W-1:0]        w_l3 [4];
  logic [PROD_W-1:0]        w_l4 [3];
  logic [PROD_W-1:0]        w_l5 [2];
  logic [PROD_W-1:0]        w_sum;
  logic [PROD_W-1:0]        r_out;

  booth_radix_8 booth_radix_8_1 (
    .b     (b),
    .one   (w_one),
    .two   (w_two),
    .three (w_three),
    .four  (w_four),
    .neg   (w_neg)
  );

  assign w_a1 = {2'b00, a};
  assign w_a2 = {1'b0, a, 1'b0};
  assign w_a4 = {a, 2'b00};
  assign w_a3 = w_a1 + w_a2;

  always_comb begin
    pp    = '0;
    w_mag = '0;
    w_ext = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      w_mag = ({(OPND_W+2){w_one[i]}}   & w_a1) |
              ({(OPND_W+2){w_two[i]}}   & w_a2) |
              ({(OPND_W+2){w_three[i]}} & w_a3) |
              ({(OPND_W+2){w_four[i]}}  & w_a4);
      w_ext = {{(PROD_W-OPND_W-2){1'b0}}, w_mag};
      if (w_neg[i]) w_ext = ~w_ext + 1'b1;
      pp[PROD_W*i +: PROD_W] = w_ext << (BOOTH_GRP*i);
    end
  end

  genvar k;
  for (k = 0; k < 3; k++) begin : g_l1
    assign w_l1[2*k]   = csa_sum  (pp[PROD_W*(3*k) +: PROD_W], pp[PROD_W*(3*k+1) +: PROD_W],
                                   pp[PROD_W*(3*k+2) +: PROD_W]);
    assign w_l1[2*k+1] = csa_carry(pp[PROD_W*(3*k) +: PROD_W], pp[PROD_W*(3*k+1) +: PROD_W],
                                   pp[PROD_W*(3*k+2) +: PROD_W]);
  end
  assign w_l1[6] = pp[PROD_W*9  +: PROD_W];
  assign w_l1[7] = pp[PROD_W*10 +: PROD_W];

  for (k = 0; k < 2; k++) begin : g_l2
    assign w_l2[2*k]   = csa_sum  (w_l1[3*k], w_l1[3*k+1], w_l1[3*k+2]);
    assign w_l2[2*k+1] = csa_carry(w_l1[3*k], w_l1[3*k+1], w_l1[3*k+2]);
  end
  assign w_l2[4] = w_l1[6];
  assign w_l2[5] = w_l1[7];

  for (k = 0; k < 2; k++) begin : g_l3
    assign w_l3[2*k]   = csa_sum  (w_l2[3*k], w_l2[3*k+1], w_l2[3*k+2]);
    assign w_l3[2*k+1] = csa_carry(w_l2[3*k], w_l2[3*k+1], w_l2[3*k+2]);
  end

  assign w_l4[0] = csa_sum  (w_l3[0], w_l3[1], w_l3[2]);
  assign w_l4[1] = csa_carry(w_l3[0], w_l3[1], w_l3[2]);
  assign w_l4[2] = w_l3[3];

  assign w_l5[0] = csa_sum  (w_l4[0], w_l4[1], w_l4[2]);
  assign w_l5[1] = csa_carry(w_l4[0], w_l4[1], w_l4[2]);

  assign w_sum = w_l5[0] + w_l5[1];

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_sum;
  end

  assign out = r_out;
endmodule

// File: tb/tb_wallace_tree_multiplier_32.sv
// Directed and random checks of the 32x32 multiplier against plain a*b.
module tb_wallace_tree_multiplier_32;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [63:0] out;
  int          n_vec  = 0;
  int          n_fail = 0;

  wallace_tree_multiplier_32 dut (.clk(clk), .rst(rst), .a(a), .b(b), .out(out));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dump_groups(input logic [31:0] y);
    logic [33:0] bx;
    int          d;
    bx = {1'b0, y, 1'b0};
    for (int i = 0; i < 11; i++) begin
      d = -4*int'(bx[3*i+3]) + 2*int'(bx[3*i+2]) + int'(bx[3*i+1]) + int'(bx[3*i]);
      $display("  group %0d: d=%0d pp=%h", i, d, dut.pp[64*i +: 64]);
    end
  endtask

  // Apply operands, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [31:0] x, input logic [31:0] y);
    rst = r; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] exp;
    logic [63:0] q [$];

    rst = 1'b1; a = '0; b = '0;

    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("reset_out", out, 64'h0);
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("all_ones", out, 64'hFFFF_FFFE_0000_0001);

    step(1'b0, 32'h0, 32'h1234_5678);
    chk("zero_a", out, 64'h0);
    step(1'b0, 32'h1, 32'h8000_0000);
    chk("identity", out, 64'h0000_0000_8000_0000);

    step(1'b0, 32'h1234_5678, 32'd3);
    chk("times3", out, 64'h0000_0000_369D_0368);
    chk("three0", {63'b0, dut.booth_radix_8_1.three[0]}, 64'd1);
    chk("neg0_b3", {63'b0, dut.booth_radix_8_1.neg[0]}, 64'd0);
    step(1'b0, 32'h1234_5678, 32'd4);
    chk("times4", out, 64'h0000_0000_48D1_59E0);
    chk("four0", {63'b0, dut.booth_radix_8_1.four[0]}, 64'd1);
    chk("neg0_b4", {63'b0, dut.booth_radix_8_1.neg[0]}, 64'd1);
    chk("one1_b4", {63'b0, dut.booth_radix_8_1.one[1]}, 64'd1);

    step(1'b0, 32'hFFFF_FFFF, 32'hE000_0000);
    chk("top_group", out, 64'hDFFF_FFFF_2000_0000);
    chk("four10", {63'b0, dut.booth_radix_8_1.four[10]}, 64'd1);

    step(1'b0, 32'd7, 32'h0000_0000);
    chk("zero_b", out, 64'h0);
    step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("a_times_1", out, 64'h0000_0000_FFFF_FFFF);

    // Back-to-back: product must appear after the edge and hold until the next.
    step(1'b0, 32'd1000, 32'd3000);
    chk("b2b_0", out, 64'd3000000);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk);
    chk("b2b_0_hold", out, 64'd3000000);
    @(posedge clk); #1;
    chk("b2b_1", out, ref_mul(32'hDEAD_BEEF, 32'h0BAD_F00D));
    step(1'b0, 32'h8000_0001, 32'hFFFF_FFFE);
    chk("b2b_2", out, ref_mul(32'h8000_0001, 32'hFFFF_FFFE));

    // Mid-stream reset discards the in-flight product; release reloads.
    step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("mid_reset", out, 64'h0);
    step(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("post_reset", out, ref_mul(32'h1234_5678, 32'h9ABC_DEF0));

    // Pipelined random run: drive every cycle, compare against queued model.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_FFFF;
        2: rb = rb & 32'h4924_9249;
        default: ;
      endcase
      step(1'b0, ra, rb);
      exp = ref_mul(ra, rb);
      q.push_back(exp);
      exp = q.pop_front();
      if (out !== exp) begin
        $display("random vector %0d: a=%h b=%h", i, ra, rb);
        dump_groups(rb);
      end
      chk("random", out, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/wallace_tree_multiplier_32.md
# wallace_tree_multiplier_32

Unsigned 32×32→64-bit multiplier built from radix-8 Booth recoding and a Wallace carry-save reduction tree, with a final carry-propagate adder and a single output register. It serves as the arithmetic core of the TMUL datapath. Inputs are sampled every cycle with no handshake, and the product appears one clock later.

## Interface
- No parameters. Width constants come from the shared package.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `a`  input  32  multiplicand, unsigned.
- `b`  input  32  multiplier, unsigned; this operand is Booth-recoded.
- `out`  output  64  registered product a·b, unsigned.

## Operation
- **Booth groups.** Zero-extend b to 34 bits: b[-1]=0 and b[32]=0. Form 11 overlapping 4-bit groups s_i = {b[3i+2], b[3i+1], b[3i], b[3i-1]} for i=0..10.
  - s_0 = {b[2:0], 1'b0}.
  - s_10 = {1'b0, b[31:29]}.
- **Booth digit.** d_i = −4·s[3] + 2·s[2] + s[1] + s[0], with range −4..+4.
- **Encoder outputs.** Per-group one-hot magnitude vectors `one`, `two`, `three`, `four` (11 bits each) and `neg` (11 bits).
  - All four magnitude bits are 0 when d_i = 0.
  - `neg` is 0 whenever d_i = 0, so no −0 is produced.
- **Hard multiple.** 3a is precomputed once with a 34-bit adder (a + 2a).
  - 2a and 4a are plain shifts.
- **Partial products.** pp_i = d_i·a, formed as a 64-bit two's-complement value (negate by invert-plus-one, or by invert with a +1 injected into the tree at column 3i), then shifted left by 3i.
  - Bits above 63 are discarded.
  - The 11 partial products are packed on an internal bus `pp[703:0]`, with pp_i at `pp[64i+63:64i]`. This bus stays a named, probe-visible signal.
- **Reduction.** Wallace reduction uses 3:2 carry-save adders (full/half adders) at 64-bit width, with carries shifted left by 1 and bit 64 dropped.
  - Levels: 11→8→6→4→3→2 (5 CSA levels).
  - The final 64-bit carry-propagate adder produces the product modulo 2^64. This equals the exact a·b because both operands are unsigned 32-bit.
- **Result.** The result is exact for every input pair, including 0, all-ones, and digits ±3/±4 in every group position. There is no overflow case.

## Timing
- Recoding, partial-product generation, reduction and the final adder are combinational from a/b.
- One register stage drives `out`.
- **Latency:** 1 cycle. The value of a/b present at rising edge k appears on `out` after edge k and holds until edge k+1.
- **Throughput:** 1 product per cycle; inputs may change every cycle.
- **Reset:** when rst=1 at a rising edge, out = 64'h0 after that edge, regardless of a/b.
  - Reset asserted mid-stream discards the in-flight product.
  - The first edge with rst=0 loads the current a·b.
- There is no valid/ready handshake and no other state.

## Structure
- **Shared package `tmul_pkg`:** OPND_W=32, PROD_W=64, BOOTH_GRP=3, NUM_PP=11.
- **Sub-module `booth_radix_8`:**
  - Input b[31:0].
  - Outputs `one`, `two`, `three`, `four`, `neg` (each [10:0]).
  - It is instantiated once in the top as `booth_radix_8_1`. The instance and its output names are stable for hierarchical probing.
- **Top level:** holds the 3a adder, the pp mux/negation, the CSA tree (full/half adders may be functions or generate loops), the final adder, and the output register.

## Test plan
- **Reset:** rst=1 with a=32'hFFFFFFFF, b=32'hFFFFFFFF → out=0 next cycle. Deassert → out=64'hFFFFFFFE00000001 one cycle later.
- **Zero / identity:** a=0, b=32'h12345678 → out=0. Then a=1, b=32'h80000000 → out=64'h0000000080000000.
- **Hard multiple ±3, ±4:**
  - a=32'h12345678, b=3 (d_0=+3) → out=64'h00000000369D0368.
  - b=4 (d_0=−4, d_1=+1) → out=64'h0000000048D159E0.
  - Check that `booth_radix_8_1.three[0]`=1 for b=3 and `four[0]`=1 with `neg[0]`=1 for b=4.
- **Top group:** a=32'hFFFFFFFF, b=32'hE0000000 → out=64'hDFFFFFFF20000000. This exercises s_10=4'b0111 (d_10=+4) together with the negative d_9.
- **Back-to-back:** apply new a/b every cycle for 3 cycles → each product appears exactly 1 cycle after its operands, with no stall or repeat.
- **Random:** 1000 random a/b pairs → out equals the reference a·b (64-bit unsigned) one cycle later. On a mismatch, dump d_i and pp_i for all 11 groups.
